piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 78 +++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: LSB-first parallel-to-serial framer; define PARITY_EN to append an even-parity bit
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic hold_q;
  // hold is registered so the strobe and the freeze act on the same cycle with no input-to-output path
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      hold_q <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      cnt    <= cnt_n;
      hold_q <= hold;
    end
  // next-state: capture in IDLE, shift unless held, one DONE cycle then back to IDLE
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    if (state == IDLE && load_valid) begin
      state_n = SHIFT;
      sr_n    = load_data;
      cnt_n   = '0;
    end else if (state == SHIFT && !hold_q) begin
      sr_n  = sr >> 1;
      cnt_n = (cnt == LAST) ? cnt : cnt + 1'b1;
`ifdef PARITY_EN
      state_n = (cnt == LAST) ? PARITY : SHIFT;
    end else if (state == PARITY && !hold_q) begin
      state_n = DONE;
`else
      state_n = (cnt == LAST) ? DONE : SHIFT;
`endif
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
`ifdef PARITY_EN
  logic par;
  // even parity of the whole word, taken when the word is captured
  always_ff @(posedge clk or posedge rst)
    if (rst) par <= 1'b0;
    else if (state == IDLE && load_valid) par <= ^load_data;
  assign ser_en  = (state == SHIFT || state == PARITY) && !hold_q;
  assign ser_out = (state == SHIFT) ? sr[0] : (state == PARITY) && par;
`else
  assign ser_en  = (state == SHIFT) && !hold_q;
  assign ser_out = (state == SHIFT) && sr[0];
`endif
  assign load_ready = state == IDLE;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
endmodule
